// File: rtl/even_parity_pkg.sv
// Shared definitions for the even-parity link: FSM state encoding and line levels.
package even_parity_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

    localparam logic TXD_IDLE  = 1'b1;
    localparam logic TXD_START = 1'b0;

endpackage

// File: rtl/even_parity_gen.sv
// Combinational even-parity generator: parity makes popcount(data)+parity even.
module even_parity_gen #(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] data,
    output logic              parity
);

    assign parity = ^data;

endmodule

// File: rtl/even_parity_frame_tx.sv
// Even-parity frame transmitter: start, DATA_W data bits LSB first, parity, stop.
// Every output is a flop; next values are decoded from the next state so txd never glitches.
module even_parity_frame_tx
    import even_parity_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              txd,
    output logic              par_out,
    output logic              busy,
    output logic              done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_q, par_d;
    logic                txd_q, txd_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                ready_q, ready_d;

    logic                din_par;
    logic                accept;
    logic                baud_end;
    logic                bit_end;

    even_parity_gen #(.DATA_W(DATA_W)) u_par_gen (
        .data   (din),
        .parity (din_par)
    );

    assign accept   = din_valid & ready_q;
    assign baud_end = (baud_q == BAUD_LAST);
    assign bit_end  = (bit_q == BIT_LAST);

    // State register plus all registered outputs; reset forces the idle line at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= TXD_IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, independent of statement order.
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    // Next state, baud counter, bit index, shift register and latched parity.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;

        if (state_q != ST_IDLE) begin
            baud_d = baud_end ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_START;
                    baud_d  = '0;
                    bit_d   = '0;
                    shift_d = din;
                    par_d   = din_par;
                end
            end
            ST_START: begin
                if (baud_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (baud_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_end) begin
                        state_d = ST_PARITY;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (baud_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (baud_end) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Output decode from the next state, so each output is a flop with no combinational path.
    always_comb begin
        txd_d = TXD_IDLE;
        case (state_d)
            ST_START:  txd_d = TXD_START;
            ST_DATA:   txd_d = shift_d[0];
            ST_PARITY: txd_d = par_d;
            default:   txd_d = TXD_IDLE;
        endcase
        done_d  = (state_d == ST_STOP) && (baud_d == BAUD_LAST);
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

    assign din_ready = ready_q;
    assign txd       = txd_q;
    assign par_out   = par_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_even_parity_frame_tx.sv
// Self-checking bench: a 4-cycles-per-bit transmitter and a 1-cycle-per-bit transmitter.
module tb_even_parity_frame_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] din0, din1;
    logic       v0, v1;
    logic       rdy0, txd0, par0, busy0, done0;
    logic       rdy1, txd1, par1, busy1, done1;

    int sel;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    even_parity_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .din(din0), .din_valid(v0), .din_ready(rdy0),
        .txd(txd0), .par_out(par0), .busy(busy0), .done(done0)
    );

    even_parity_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din1), .din_valid(v1), .din_ready(rdy1),
        .txd(txd1), .par_out(par1), .busy(busy1), .done(done1)
    );

    typedef struct {
        logic [3:0] din;
        int         sel;
        logic       exp_par;
        logic [0:6] seq;   // line level of each bit slot in transmit order
    } vec_t;

    vec_t vecs[6];

    function automatic logic o_txd();   return (sel == 1) ? txd1  : txd0;  endfunction
    function automatic logic o_ready(); return (sel == 1) ? rdy1  : rdy0;  endfunction
    function automatic logic o_par();   return (sel == 1) ? par1  : par0;  endfunction
    function automatic logic o_busy();  return (sel == 1) ? busy1 : busy0; endfunction
    function automatic logic o_done();  return (sel == 1) ? done1 : done0; endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t actual=%b expected=%b", name, sel, $time, act, exp);
        end
    endtask

    task automatic check_nib(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t actual=%b expected=%b", name, sel, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input logic [3:0] d, input logic v);
        if (s == 1) begin din1 = d; v1 = v; end
        else        begin din0 = d; v0 = v; end
    endtask

    // Reference model: number of ones decides parity; frame is start, data LSB first, parity, stop.
    function automatic int ones_of(input logic [3:0] d);
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(d[i]);
        return n;
    endfunction

    function automatic logic model_par(input logic [3:0] d);
        return (ones_of(d) % 2) == 1;
    endfunction

    function automatic logic [0:6] model_seq(input logic [3:0] d);
        logic [0:6] s;
        s[0] = 1'b0;
        for (int i = 0; i < 4; i++) s[i + 1] = d[i];
        s[5] = model_par(d);
        s[6] = 1'b1;
        return s;
    endfunction

    // One full frame: accept, per-cycle line/flag checks, mid-bit loopback, idle gap check.
    task automatic run_frame(input int s, input logic [3:0] d, input logic exp_par,
                             input logic [0:6] seq, input bit keep_valid);
        int         cpb;
        int         len;
        int         n;
        int         b;
        logic [3:0] rx;
        logic       rx_par;
        sel    = s;
        cpb    = (s == 1) ? 1 : 4;
        len    = 7 * cpb;
        rx     = '0;
        rx_par = 1'b0;
        n      = 0;
        while (!o_ready() && n < 200) begin
            tick();
            n++;
        end
        check("ready_before_accept", o_ready(), 1'b1);
        drive(s, d, 1'b1);
        tick();
        if (keep_valid) drive(s, ~d, 1'b1);
        else            drive(s, 4'($urandom), 1'b0);
        for (int k = 1; k <= len; k++) begin
            b = (k - 1) / cpb;
            check("txd", o_txd(), seq[b]);
            check("busy", o_busy(), 1'b1);
            check("din_ready_busy", o_ready(), 1'b0);
            check("par_out", o_par(), exp_par);
            check("done", o_done(), k == len);
            if ((k - 1) % cpb == cpb / 2) begin
                if (b >= 1 && b <= 4) rx[b - 1] = o_txd();
                if (b == 5) rx_par = o_txd();
            end
            tick();
        end
        check("gap_txd", o_txd(), 1'b1);
        check("gap_busy", o_busy(), 1'b0);
        check("gap_ready", o_ready(), 1'b1);
        check("gap_done", o_done(), 1'b0);
        check_nib("loop_data", rx, d);
        check("loop_parity_err", (ones_of(rx) + int'(rx_par)) % 2 == 1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{din: 4'b1011, sel: 0, exp_par: 1'b1, seq: 7'b0110111};
        vecs[1] = '{din: 4'b0000, sel: 0, exp_par: 1'b0, seq: 7'b0000001};
        vecs[2] = '{din: 4'b1111, sel: 0, exp_par: 1'b0, seq: 7'b0111101};
        vecs[3] = '{din: 4'b0110, sel: 1, exp_par: 1'b0, seq: 7'b0011001};
        vecs[4] = '{din: 4'b0001, sel: 0, exp_par: 1'b1, seq: 7'b0100011};
        vecs[5] = '{din: 4'b1000, sel: 1, exp_par: 1'b1, seq: 7'b0000111};

        din0 = '0; v0 = 1'b0; din1 = '0; v1 = 1'b0; sel = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            check("rst_txd", o_txd(), 1'b1);
            check("rst_ready", o_ready(), 1'b1);
            check("rst_busy", o_busy(), 1'b0);
            check("rst_done", o_done(), 1'b0);
            check("rst_par", o_par(), 1'b0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed vectors with hand-derived frames.
        for (int i = 0; i < 6; i++)
            run_frame(vecs[i].sel, vecs[i].din, vecs[i].exp_par, vecs[i].seq, 1'b0);

        // valid held high with changing din during a frame, then back-to-back accept.
        run_frame(0, 4'b1010, 1'b0, 7'b0010101, 1'b1);
        run_frame(0, 4'b0111, 1'b1, 7'b0111011, 1'b0);
        run_frame(1, 4'b1101, 1'b1, 7'b0101111, 1'b1);
        run_frame(1, 4'b0011, 1'b0, 7'b0110001, 1'b0);

        // Reset in cycle 10 of a frame aborts it immediately and cleanly.
        sel = 0;
        drive(0, 4'b1011, 1'b1);
        tick();
        drive(0, 4'b0000, 1'b0);
        repeat (9) tick();
        check("pre_reset_busy", o_busy(), 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_txd", o_txd(), 1'b1);
        check("mid_rst_busy", o_busy(), 1'b0);
        check("mid_rst_ready", o_ready(), 1'b1);
        check("mid_rst_done", o_done(), 1'b0);
        check("mid_rst_par", o_par(), 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            check("post_rst_done", o_done(), 1'b0);
            check("post_rst_txd", o_txd(), 1'b1);
            tick();
        end
        run_frame(0, 4'b1011, 1'b1, 7'b0110111, 1'b0);

        // Loopback over every data word, both bit rates.
        for (int v = 0; v < 16; v++) begin
            run_frame(0, 4'(v), model_par(4'(v)), model_seq(4'(v)), 1'b0);
            run_frame(1, 4'(v), model_par(4'(v)), model_seq(4'(v)), 1'b0);
        end

        // Random words, random DUT choice, random idle gaps.
        for (int r = 0; r < 40; r++) begin
            int         s;
            logic [3:0] d;
            s = int'($urandom_range(0, 1));
            d = 4'($urandom);
            run_frame(s, d, model_par(d), model_seq(d), 1'b0);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
